calc_op_sequencer: RTL and testbench

- Controller between the board button/switches and a multi-cycle calculator ALU.
- Debounces `button` and latches `func`/`num1`/`num2` on a press.
- Launches the ALU with a one-cycle start pulse, waits for done with a timeout, then registers `cal_result` for the display and flags errors.
- Sits between the top level and the ALU/display, on the divided clock domain.

---
 rtl/calc_op_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_sequencer
// Brief    : Button-driven sequencer for a multi-cycle calculator ALU.
//            Synchronizes and debounces the push-button, latches the operand
//            switches on a press, launches the ALU with a one-cycle start
//            pulse, waits for completion with a timeout, and publishes the
//            result, an error flag and a completed-operation count.
// Revision : 1.0 - initial release
// ============================================================================
module calc_op_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter int unsigned MAX_FUNC        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic [2:0]  func,
    input  logic [7:0]  num1,
    input  logic [7:0]  num2,
    input  logic        alu_done,
    input  logic        alu_err,
    input  logic [31:0] alu_result,
    output logic        alu_start,
    output logic [2:0]  alu_func,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [31:0] cal_result,
    output logic        result_valid,
    output logic        busy,
    output logic        err,
    output logic [7:0]  op_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned c_DBW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned c_TOW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    // The debounce counter flips the level on the cycle its count would reach
    // DEBOUNCE_CYCLES, so the compare value is one less than the threshold.
    localparam logic [c_DBW-1:0] c_DB_LAST  = c_DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TOW-1:0] c_TO_LAST  = c_TOW'(TIMEOUT_CYCLES - 1);

    // A 3-bit code can never exceed a limit of 7 or more.
    localparam bit               c_ALL_LEGAL = (MAX_FUNC >= 7);
    localparam logic [2:0]       c_MAX_FUNC  = 3'(MAX_FUNC);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LAUNCH = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]        r_sync;
    logic [c_DBW-1:0]  r_db_cnt;
    logic              r_db_level;
    logic              r_press;
    logic              w_db_diff;
    logic              w_db_flip;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_TOW-1:0]  r_to_cnt;

    logic              w_func_bad;
    logic              w_accept;
    logic              w_set_err;
    logic              w_load_res;
    logic              w_enter_done;

    logic [2:0]        r_alu_func;
    logic [7:0]        r_alu_a;
    logic [7:0]        r_alu_b;
    logic [31:0]       r_cal_result;
    logic              r_err;
    logic [7:0]        r_op_count;

    // ------------------------------------------------------------------------
    // Button path
    // ------------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous push-button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], button};
        end
    end

    assign w_db_diff = (r_sync[1] != r_db_level);
    assign w_db_flip = w_db_diff && (r_db_cnt == c_DB_LAST);

    // Debounce: the level only follows the synced input after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; press marks a rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_press <= w_db_flip && !r_db_level;
            if (w_db_flip) begin
                r_db_level <= ~r_db_level;
                r_db_cnt   <= '0;
            end else if (w_db_diff) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Operation sequencer
    // ------------------------------------------------------------------------
    assign w_func_bad = !c_ALL_LEGAL && (func > c_MAX_FUNC);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the one-cycle datapath strobes for each transition.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_set_err   = 1'b0;
        w_load_res  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_press) begin
                    w_accept = 1'b1;
                    // Illegal codes skip the ALU entirely but still complete.
                    if (w_func_bad) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_LAUNCH;
                    end
                end
            end
            c_LAUNCH: begin
                // A done seen while the start pulse is out cannot belong to it.
                w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                // Done has priority over a timeout landing in the same cycle.
                if (alu_done) begin
                    w_state_nxt = c_DONE;
                    if (alu_err) begin
                        w_set_err = 1'b1;
                    end else begin
                        w_load_res = 1'b1;
                    end
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_state_nxt = c_DONE;
                    w_set_err   = 1'b1;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign w_enter_done = (r_state != c_DONE) && (w_state_nxt == c_DONE);

    // Timeout counter: restarted by the launch, advanced on each idle WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (r_state == c_LAUNCH) begin
            r_to_cnt <= '0;
        end else if ((r_state == c_WAIT) && !alu_done) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Operand latch, result/error capture and completion counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_func   <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_cal_result <= '0;
            r_err        <= 1'b0;
            r_op_count   <= '0;
        end else begin
            if (w_accept) begin
                r_alu_func <= func;
                r_alu_a    <= num1;
                r_alu_b    <= num2;
                // A new press clears the old error unless it is rejected.
                r_err      <= w_func_bad;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_load_res) begin
                r_cal_result <= alu_result;
            end
            // Counted on entry to DONE so the count is current while
            // result_valid is high; rejected and failed ops count too.
            if (w_enter_done) begin
                r_op_count <= r_op_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign alu_start    = (r_state == c_LAUNCH);
    assign result_valid = (r_state == c_DONE);
    assign busy         = (r_state != c_IDLE);
    assign alu_func     = r_alu_func;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign cal_result   = r_cal_result;
    assign err          = r_err;
    assign op_count     = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_op_sequencer
// Brief    : Self-checking bench for calc_op_sequencer: directed button and
//            ALU stimulus, a cycle-stamped behavioural model compared every
//            cycle, and hand-computed latency/value checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_op_sequencer;

    localparam int DB = 4;
    localparam int TO = 8;
    localparam int MF = 4;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        button     = 1'b0;
    logic [2:0]  func       = 3'd0;
    logic [7:0]  num1       = 8'd0;
    logic [7:0]  num2       = 8'd0;
    logic        alu_done   = 1'b0;
    logic        alu_err    = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic        alu_start;
    logic [2:0]  alu_func;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [31:0] cal_result;
    logic        result_valid;
    logic        busy;
    logic        err;
    logic [7:0]  op_count;

    calc_op_sequencer #(
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TO),
        .MAX_FUNC        (MF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button       (button),
        .func         (func),
        .num1         (num1),
        .num2         (num2),
        .alu_done     (alu_done),
        .alu_err      (alu_err),
        .alu_result   (alu_result),
        .alu_start    (alu_start),
        .alu_func     (alu_func),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .cal_result   (cal_result),
        .result_valid (result_valid),
        .busy         (busy),
        .err          (err),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int tcyc     = 0;

    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: operations tracked by the cycle numbers at which
    // they were accepted, launched and finished.
    // ------------------------------------------------------------------------
    int          m_cyc    = 0;
    int          m_n      = 0;
    logic        m_s1     = 1'b0;
    logic        m_s2     = 1'b0;
    logic        m_level  = 1'b0;
    int          m_run    = 0;
    logic        e_press  = 1'b0;
    bit          op_act   = 1'b0;
    int          acc_c    = 0;
    int          launch_c = -1;
    int          fin_c    = -1;
    bit          fin_err  = 1'b0;
    logic [31:0] fin_res  = 32'd0;
    logic        e_start  = 1'b0;
    logic        e_rv     = 1'b0;
    logic        e_busy   = 1'b0;
    logic        e_err    = 1'b0;
    logic [2:0]  e_func   = 3'd0;
    logic [7:0]  e_a      = 8'd0;
    logic [7:0]  e_b      = 8'd0;
    logic [7:0]  e_cnt    = 8'd0;
    logic [31:0] e_cal    = 32'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc = 0; m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; e_press = 0;
            op_act = 0; acc_c = 0; launch_c = -1; fin_c = -1; fin_err = 0; fin_res = 0;
            e_start = 0; e_rv = 0; e_busy = 0; e_err = 0;
            e_func = 0; e_a = 0; e_b = 0; e_cnt = 0; e_cal = 0;
        end else begin
            m_n = m_cyc + 1;
            // Completion of a launched op, judged from what happened in cycle m_cyc.
            if (op_act && launch_c >= 0 && fin_c < 0) begin
                if (m_cyc > launch_c && alu_done) begin
                    fin_c = m_n; fin_err = alu_err; fin_res = alu_result;
                end else if (m_cyc == launch_c + TO) begin
                    fin_c = m_n; fin_err = 1'b1;
                end
            end
            // A press seen while idle starts an op; otherwise it is lost.
            if (e_press && !e_busy) begin
                op_act = 1'b1; acc_c = m_cyc;
                e_func = func; e_a = num1; e_b = num2; e_err = 1'b0;
                if (int'(func) > MF) begin
                    launch_c = -1; fin_c = m_n; fin_err = 1'b1;
                end else begin
                    launch_c = m_n; fin_c = -1;
                end
            end
            e_start = op_act && (launch_c == m_n);
            e_rv    = op_act && (fin_c == m_n);
            if (e_rv) begin
                e_cnt = e_cnt + 8'd1;
                if (fin_err) e_err = 1'b1;
                else         e_cal = fin_res;
            end
            e_busy = op_act && (m_n > acc_c) && (fin_c < 0 || m_n <= fin_c);
            if (op_act && fin_c >= 0 && m_n > fin_c) op_act = 1'b0;
            // Debounce: level follows the synced button after DB disagreeing cycles.
            e_press = 1'b0;
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == DB) begin
                    m_level = ~m_level;
                    m_run   = 0;
                    e_press = m_level;
                end
            end else begin
                m_run = 0;
            end
            m_s2  = m_s1;
            m_s1  = button;
            m_cyc = m_n;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("alu_start",    alu_start,    e_start);
        check("result_valid", result_valid, e_rv);
        check("busy",         busy,         e_busy);
        check("alu_func",     alu_func,     e_func);
        check("alu_a",        alu_a,        e_a);
        check("alu_b",        alu_b,        e_b);
        check("cal_result",   cal_result,   e_cal);
        check("err",          err,          e_err);
        check("op_count",     op_count,     e_cnt);
    end

    // Event monitor used by the directed literal checks.
    int n_start   = 0;
    int n_rv      = 0;
    int start_cyc = 0;
    int rv_cyc    = 0;

    always @(negedge clk) begin
        if (alu_start)    begin n_start++; start_cyc = tcyc; end
        if (result_valid) begin n_rv++;    rv_cyc    = tcyc; end
    end

    // ALU stand-in: answers stub_delay cycles after a start (0 = never).
    int          stub_delay = 0;
    logic        stub_err   = 1'b0;
    logic [31:0] stub_res   = 32'd0;
    bit          stub_armed = 1'b0;
    int          stub_cnt   = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) stub_armed = 1'b0;
        else if (alu_start) begin stub_armed = 1'b1; stub_cnt = 0; end
        else if (stub_armed) stub_cnt++;
        if (stub_armed && stub_delay > 0 && stub_cnt == stub_delay) begin
            alu_done = 1'b1; alu_err = stub_err; alu_result = stub_res; stub_armed = 1'b0;
        end else begin
            alu_done = 1'b0; alu_err = 1'b0; alu_result = 32'hBAD0_0000;
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    int bcyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin step(); k++; end
        check("wait_idle", busy, 1'b0);
    endtask

    task automatic do_press();
        button = 1'b1; bcyc = tcyc;
        repeat (10) step();
        button = 1'b0;
        repeat (8) step();
        wait_idle();
    endtask

    int s0, r0;

    initial begin
        rst = 1'b0;
        repeat (3) step();
        check("reset_busy",  busy,       1'b0);
        check("reset_start", alu_start,  1'b0);
        check("reset_rv",    result_valid, 1'b0);
        check("reset_outs",  {alu_func, alu_a, alu_b, err, op_count}, 32'd0);
        check("reset_cal",   cal_result, 32'd0);
        rst = 1'b1;
        repeat (3) step();

        // Clean press, ALU answers 3 cycles after start.
        func = 3'd0; num1 = 8'h12; num2 = 8'h34;
        stub_delay = 3; stub_err = 1'b0; stub_res = 32'h46;
        s0 = n_start; r0 = n_rv;
        do_press();
        check("clean_starts",  n_start - s0, 1);
        check("clean_start_lat", start_cyc - bcyc, 7);
        check("clean_rv_lat",  rv_cyc - bcyc, 11);
        check("clean_a",       alu_a, 8'h12);
        check("clean_b",       alu_b, 8'h34);
        check("clean_cal",     cal_result, 32'h46);
        check("clean_count",   op_count, 8'd1);
        check("clean_err",     err, 1'b0);

        // Divide by zero keeps the previous result.
        func = 3'd3; num1 = 8'h09; num2 = 8'h00;
        stub_delay = 2; stub_err = 1'b1; stub_res = 32'hDEAD_BEEF;
        r0 = n_rv;
        do_press();
        check("div0_err",   err, 1'b1);
        check("div0_cal",   cal_result, 32'h46);
        check("div0_rv",    n_rv - r0, 1);
        check("div0_count", op_count, 8'd2);

        // Bouncy button: fast toggling is filtered, then one clean press.
        func = 3'd1; num1 = 8'h05; num2 = 8'h06;
        stub_delay = 2; stub_err = 1'b0; stub_res = 32'h0B;
        s0 = n_start;
        for (int i = 0; i < 10; i++) begin
            button = ~button;
            repeat (2) step();
        end
        do_press();
        check("bouncy_starts", n_start - s0, 1);
        check("bouncy_lat",    start_cyc - bcyc, 7);
        check("bouncy_cal",    cal_result, 32'h0B);

        // Three-cycle glitch is shorter than the debounce window.
        s0 = n_start; r0 = n_rv;
        button = 1'b1;
        repeat (3) step();
        button = 1'b0;
        repeat (15) step();
        check("glitch_starts", n_start - s0, 0);
        check("glitch_rv",     n_rv - r0, 0);

        // ALU never answers: timeout.
        func = 3'd2; num1 = 8'h01; num2 = 8'h02;
        stub_delay = 0;
        do_press();
        check("timeout_lat",  rv_cyc - start_cyc, 9);
        check("timeout_err",  err, 1'b1);
        check("timeout_cal",  cal_result, 32'h0B);
        check("timeout_busy", busy, 1'b0);

        // Illegal function code is rejected without launching.
        func = 3'b111; num1 = 8'hA0; num2 = 8'hA1;
        s0 = n_start;
        do_press();
        check("badfunc_starts", n_start - s0, 0);
        check("badfunc_lat",    rv_cyc - bcyc, 7);
        check("badfunc_err",    err, 1'b1);
        check("badfunc_func",   alu_func, 3'b111);

        // Second press and switch change while busy are ignored; done on the
        // last WAIT cycle still wins over the timeout.
        func = 3'd1; num1 = 8'h21; num2 = 8'h02;
        stub_delay = 8; stub_err = 1'b0; stub_res = 32'h23;
        s0 = n_start; r0 = n_rv;
        button = 1'b1; bcyc = tcyc;
        repeat (6) step();
        button = 1'b0;
        repeat (4) step();
        button = 1'b1; num1 = 8'h77;
        repeat (10) step();
        button = 1'b0;
        repeat (8) step();
        wait_idle();
        check("busy_starts", n_start - s0, 1);
        check("busy_rv",     n_rv - r0, 1);
        check("busy_a",      alu_a, 8'h21);
        check("busy_cal",    cal_result, 32'h23);
        check("busy_err",    err, 1'b0);

        // Asynchronous reset in WAIT aborts with no result_valid.
        func = 3'd0; num1 = 8'h55; num2 = 8'h01;
        stub_delay = 0;
        s0 = n_start;
        button = 1'b1;
        for (int k = 0; k < 30 && n_start == s0; k++) step();
        check("rst_launch", n_start - s0, 1);
        repeat (2) step();
        r0 = n_rv;
        #2 rst = 1'b0;
        #1;
        check("rst_outs", {alu_start, result_valid, busy, err, alu_func, alu_a, alu_b, op_count}, 32'd0);
        check("rst_cal",  cal_result, 32'd0);
        button = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        repeat (20) step();
        check("rst_no_rv", n_rv - r0, 0);
        check("rst_busy",  busy, 1'b0);

        // 256 operations wrap the counter.
        for (int i = 0; i < 256; i++) begin
            func = 3'(i); num1 = 8'(i); num2 = 8'(i + 1);
            stub_delay = 1 + (i % 3); stub_err = 1'b0; stub_res = 32'(i * 3);
            do_press();
            if (i == 254) check("wrap_255", op_count, 8'd255);
        end
        check("wrap_0",   op_count, 8'd0);
        check("wrap_cal", cal_result, 32'h2F4);
        check("wrap_err", err, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
